cache_arbiter: RTL and testbench

Arbitrates line-level misses and writebacks from the instruction L1 cache and the data L1 cache onto the single physical-memory port. Sits directly downstream of both caches' pmem interfaces and upstream of physical memory, and moves whole 128-bit cache lines. All three ports use the cache line-address layout: 9-bit tag, 3-bit index, 4-bit byte offset.

---
 rtl/cache_arbiter.sv | 114 +++++++++++
 tb/tb_cache_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line transactions onto one physical-memory port.
// One memory operation in flight; fixed or round-robin tie-break selected by FAIR.
module cache_arbiter #(
    parameter int FAIR = 1
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         i_pmem_read,
    input  logic [15:0]  i_pmem_address,
    output logic [127:0] i_pmem_rdata,
    output logic         i_pmem_resp,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [15:0]  d_pmem_address,
    input  logic [127:0] d_pmem_wdata,
    output logic [127:0] d_pmem_rdata,
    output logic         d_pmem_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]   r_state;
    logic         r_last_grant_d;
    logic         r_pmem_read;
    logic         r_pmem_write;
    logic [15:0]  r_pmem_address;
    logic [127:0] r_pmem_wdata;

    logic         w_i_req;
    logic         w_d_req;
    logic         w_grant_any;
    logic         w_grant_d;
    logic [15:0]  w_i_line;
    logic [15:0]  w_d_line;

    always_comb begin
        w_i_req     = i_pmem_read;
        w_d_req     = d_pmem_read | d_pmem_write;
        w_grant_any = w_i_req | w_d_req;
        // On a tie, round-robin hands the port to whichever side did not win last.
        if (w_i_req && w_d_req) begin
            w_grant_d = (FAIR != 0) ? ~r_last_grant_d : 1'b1;
        end else begin
            w_grant_d = w_d_req;
        end
        w_i_line = i_pmem_address & 16'hFFF0;
        w_d_line = d_pmem_address & 16'hFFF0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_last_grant_d <= 1'b1;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_last_grant_d <= w_grant_d;
                        if (w_grant_d) begin
                            r_state        <= ST_SERVE_D;
                            r_pmem_address <= w_d_line;
                            r_pmem_wdata   <= d_pmem_wdata;
                            // A writeback wins over a simultaneous fill request.
                            r_pmem_write   <= d_pmem_write;
                            r_pmem_read    <= ~d_pmem_write;
                        end else begin
                            r_state        <= ST_SERVE_I;
                            r_pmem_address <= w_i_line;
                            r_pmem_write   <= 1'b0;
                            r_pmem_read    <= 1'b1;
                        end
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    if (pmem_resp) begin
                        r_state      <= ST_DONE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign i_pmem_resp  = pmem_resp & (r_state == ST_SERVE_I);
    assign d_pmem_resp  = pmem_resp & (r_state == ST_SERVE_D);

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: one round-robin and one fixed-priority instance,
// directed scenarios plus random rounds against a transaction-level model.
module tb_cache_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst      [2];
    logic         i_rd     [2];
    logic [15:0]  i_ad     [2];
    logic         d_rd     [2];
    logic         d_wr     [2];
    logic [15:0]  d_ad     [2];
    logic [127:0] d_wd     [2];
    logic [127:0] mem_data [2];
    logic         mem_resp [2];

    logic [127:0] i_rdata_o [2];
    logic         i_resp_o  [2];
    logic [127:0] d_rdata_o [2];
    logic         d_resp_o  [2];
    logic         pm_rd     [2];
    logic         pm_wr     [2];
    logic [15:0]  pm_ad     [2];
    logic [127:0] pm_wd     [2];

    // Instance 0 is round-robin, instance 1 is fixed D priority.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        cache_arbiter #(.FAIR(g == 0 ? 1 : 0)) u_dut (
            .clk            (clk),
            .reset          (rst[g]),
            .i_pmem_read    (i_rd[g]),
            .i_pmem_address (i_ad[g]),
            .i_pmem_rdata   (i_rdata_o[g]),
            .i_pmem_resp    (i_resp_o[g]),
            .d_pmem_read    (d_rd[g]),
            .d_pmem_write   (d_wr[g]),
            .d_pmem_address (d_ad[g]),
            .d_pmem_wdata   (d_wd[g]),
            .d_pmem_rdata   (d_rdata_o[g]),
            .d_pmem_resp    (d_resp_o[g]),
            .pmem_read      (pm_rd[g]),
            .pmem_write     (pm_wr[g]),
            .pmem_address   (pm_ad[g]),
            .pmem_wdata     (pm_wd[g]),
            .pmem_rdata     (mem_data[g]),
            .pmem_resp      (mem_resp[g])
        );
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model state: which side won most recently, and the line currently held for writeback.
    bit           m_last_d [2];
    logic [127:0] m_wdata  [2];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input int g, input string tag);
        check({tag, "_rd"}, pm_rd[g], 0);
        check({tag, "_wr"}, pm_wr[g], 0);
        check({tag, "_iresp"}, i_resp_o[g], 0);
        check({tag, "_dresp"}, d_resp_o[g], 0);
    endtask

    // Called with the DUT idle, at the sampling point of a cycle. Raises the given
    // requests and serves every one of them; the loser of a tie holds until served.
    task automatic run_round(input int g, input bit ir, input bit dr, input bit dw,
                             input logic [15:0] ia, input logic [15:0] da,
                             input logic [127:0] wd, input logic [127:0] rdat,
                             input int lat);
        bit pend_i, pend_d, gd, fair;
        bit exp_rd, exp_wr;
        logic [15:0] exp_ad;
        fair   = (g == 0);
        pend_i = ir;
        pend_d = dr | dw;
        i_rd[g] = ir; i_ad[g] = ia;
        d_rd[g] = dr; d_wr[g] = dw; d_ad[g] = da; d_wd[g] = wd;
        #1;
        check_quiet(g, "pre_grant");
        while (pend_i || pend_d) begin
            if (pend_i && pend_d) gd = fair ? !m_last_d[g] : 1'b1;
            else                  gd = pend_d;
            m_last_d[g] = gd;
            if (gd) m_wdata[g] = wd;
            exp_wr = gd && dw;
            exp_rd = !exp_wr;
            exp_ad = (gd ? da : ia) & 16'hFFF0;
            tick;
            #1;
            check("grant_rd", pm_rd[g], exp_rd);
            check("grant_wr", pm_wr[g], exp_wr);
            check("grant_addr", pm_ad[g], exp_ad);
            check("grant_wdata", pm_wd[g], m_wdata[g]);
            check("grant_iresp", i_resp_o[g], 0);
            check("grant_dresp", d_resp_o[g], 0);
            for (int w = 0; w < lat; w++) begin
                if (gd) d_wd[g] = {$urandom, $urandom, $urandom, $urandom};
                tick;
                #1;
                check("hold_rd", pm_rd[g], exp_rd);
                check("hold_wr", pm_wr[g], exp_wr);
                check("hold_wdata", pm_wd[g], m_wdata[g]);
                check("hold_dresp", d_resp_o[g], 0);
            end
            mem_data[g] = rdat;
            mem_resp[g] = 1'b1;
            #1;
            check("resp_i", i_resp_o[g], !gd);
            check("resp_d", d_resp_o[g], gd);
            check("rdata_i", i_rdata_o[g], rdat);
            check("rdata_d", d_rdata_o[g], rdat);
            tick;
            mem_resp[g] = 1'($urandom_range(0, 1));
            if (gd) begin d_rd[g] = 1'b0; d_wr[g] = 1'b0; pend_d = 1'b0; end
            else    begin i_rd[g] = 1'b0; pend_i = 1'b0; end
            #1;
            check_quiet(g, "done");
            tick;
            mem_resp[g] = 1'($urandom_range(0, 1));
            #1;
            check_quiet(g, "idle");
            mem_resp[g] = 1'b0;
        end
    endtask

    task automatic reset_mid_serve(input int g);
        d_wr[g] = 1'b1;
        d_ad[g] = 16'($urandom);
        d_wd[g] = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        m_wdata[g] = d_wd[g];
        #1;
        tick;
        #1;
        check("rst_pre_wr", pm_wr[g], 1);
        check("rst_pre_wdata", pm_wd[g], m_wdata[g]);
        #2;
        rst[g] = 1'b1;
        #1;
        check("rst_rd", pm_rd[g], 0);
        check("rst_wr", pm_wr[g], 0);
        check("rst_addr", pm_ad[g], 0);
        check("rst_wdata", pm_wd[g], 0);
        mem_resp[g] = 1'b1;
        #1;
        check("rst_dresp", d_resp_o[g], 0);
        check("rst_iresp", i_resp_o[g], 0);
        d_wr[g] = 1'b0;
        rst[g]  = 1'b0;
        m_last_d[g] = 1'b1;
        m_wdata[g]  = '0;
        tick;
        #1;
        check_quiet(g, "stray_idle");
        mem_resp[g] = 1'b0;
        tick;
        #1;
        check_quiet(g, "post_rst");
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1;
            i_rd[g] = 1'b0; i_ad[g] = '0;
            d_rd[g] = 1'b0; d_wr[g] = 1'b0; d_ad[g] = '0; d_wd[g] = '0;
            mem_data[g] = '0; mem_resp[g] = 1'b0;
            m_last_d[g] = 1'b1;
            m_wdata[g]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check_quiet(g, "reset");
            check("reset_addr", pm_ad[g], 0);
            check("reset_wdata", pm_wd[g], 0);
            rst[g] = 1'b0;
        end
        #1;

        // Ties from reset, then a repeated tie.
        run_round(0, 1, 1, 0, 16'h0400, 16'h0810, '0, {4{32'h1111_2222}}, 1);
        run_round(0, 1, 1, 1, 16'h0ABC, 16'h0DEF, {4{32'h0F0F_0F0F}}, {4{32'h3333_4444}}, 0);
        run_round(1, 1, 1, 0, 16'h0400, 16'h0810, '0, {4{32'h5555_6666}}, 1);
        run_round(1, 1, 1, 0, 16'h0401, 16'h0811, '0, {4{32'h7777_8888}}, 2);

        // Single I fill, D writeback, read+write conflict.
        run_round(0, 1, 0, 0, 16'h1236, 16'h0000, '0, {16{8'hA5}}, 2);
        run_round(0, 0, 0, 1, 16'h0000, 16'h8010, {4{32'hDEAD_BEEF}}, {4{32'h9999_AAAA}}, 3);
        run_round(1, 0, 1, 1, 16'h0000, 16'h4567, {4{32'hCAFE_F00D}}, {4{32'hBBBB_CCCC}}, 0);

        reset_mid_serve(0);
        reset_mid_serve(1);

        for (int r = 0; r < 60; r++) begin
            int g;
            bit ir, dr, dw;
            g  = r % 2;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ir && !dr && !dw) ir = 1'b1;
            run_round(g, ir, dr, dw, 16'($urandom), 16'($urandom),
                      {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
